// File: rtl/mpeg2_stream_pkg.sv
// Shared constants and helpers for the elementary-stream input path.
package mpeg2_stream_pkg;

  localparam int BYTE_W             = 8;
  localparam int BYTES_PER_WORD_DEF = 8;

  // Start-code prefix; consumed by the parser downstream of the stream FIFO.
  localparam logic [23:0] START_CODE_PREFIX = 24'h000001;

  function automatic int word_width(input int bpw);
    return BYTE_W * bpw;
  endfunction

endpackage

// File: rtl/mpeg2_byte_accum.sv
// Lane-indexed byte accumulator: packs bytes big-endian, emits a full or
// zero-padded word when the top level has room for it.
module mpeg2_byte_accum
  import mpeg2_stream_pkg::*;
#(
  parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEF
) (
  input  logic                                wr_clk,
  input  logic                                rst,
  input  logic [BYTE_W-1:0]                   byte_in,
  input  logic                                byte_acc,
  input  logic                                flush_req,
  input  logic                                reg_free,
  output logic                                word_load,
  output logic [BYTE_W*BYTES_PER_WORD-1:0]    word,
  output logic                                cnt_last,
  output logic                                cnt_zero
);

  localparam int WW = word_width(BYTES_PER_WORD);
  localparam int CW = $clog2(BYTES_PER_WORD);

  logic [WW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          fill_load;
  logic          pad_load;

  assign cnt_last = (cnt == CW'(BYTES_PER_WORD - 1));
  assign cnt_zero = (cnt == '0);

  // Lanes not yet written are still zero, so the same value serves as padded word.
  always_comb begin
    word = acc;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (byte_acc && (cnt == CW'(BYTES_PER_WORD - 1 - i)))
        word[i*BYTE_W +: BYTE_W] = byte_in;
    end
    fill_load = byte_acc & cnt_last;
    pad_load  = flush_req & reg_free & ~fill_load & (byte_acc | ~cnt_zero);
    word_load = fill_load | pad_load;
  end

  always_ff @(posedge wr_clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (word_load) begin
      acc <= '0;
      cnt <= '0;
    end else if (byte_acc) begin
      acc <= word;
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mpeg2_byte_packer.sv
// Write-side front end of the stream FIFO: byte handshake in, packed words
// out, with flush, full back-pressure and write/overflow bookkeeping.
module mpeg2_byte_packer
  import mpeg2_stream_pkg::*;
#(
  parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                              rst,
  input  logic                              wr_clk,
  input  logic [7:0]                        byte_in,
  input  logic                              byte_valid,
  input  logic                              byte_flush,
  output logic                              busy,
  output logic [BYTE_W*BYTES_PER_WORD-1:0]  fifo_din,
  output logic                              fifo_wr_en,
  input  logic                              fifo_full,
  input  logic                              fifo_prog_full,
  input  logic                              fifo_wr_ack,
  input  logic                              fifo_overflow,
  output logic [CNT_WIDTH-1:0]              words_written,
  output logic                              err_overflow,
  output logic                              flush_done
);

  localparam int WW = word_width(BYTES_PER_WORD);

  logic          out_vld;
  logic [WW-1:0] out_reg;
  logic          flush_pend;
  logic          byte_acc;
  logic          flush_acc;
  logic          reg_free;
  logic          word_load;
  logic [WW-1:0] word;
  logic          cnt_last;
  logic          cnt_zero;

  // busy is forced high during reset and never depends on byte_valid.
  assign busy       = ~rst | fifo_prog_full | flush_pend | (out_vld & cnt_last);
  assign byte_acc   = byte_valid & ~busy;
  assign flush_acc  = byte_flush & ~busy;
  assign fifo_wr_en = out_vld & ~fifo_full;
  assign fifo_din   = out_reg;
  assign reg_free   = ~out_vld | ~fifo_full;
  // A padded word waits here while the output register is stuck on a full FIFO.
  assign flush_done = flush_pend & ~out_vld & cnt_zero;

  mpeg2_byte_accum #(
    .BYTES_PER_WORD (BYTES_PER_WORD)
  ) u_accum (
    .wr_clk    (wr_clk),
    .rst       (rst),
    .byte_in   (byte_in),
    .byte_acc  (byte_acc),
    .flush_req (flush_acc | flush_pend),
    .reg_free  (reg_free),
    .word_load (word_load),
    .word      (word),
    .cnt_last  (cnt_last),
    .cnt_zero  (cnt_zero)
  );

  always_ff @(posedge wr_clk or negedge rst) begin
    if (!rst) begin
      out_vld <= 1'b0;
      out_reg <= '0;
    end else if (word_load) begin
      out_vld <= 1'b1;
      out_reg <= word;
    end else if (fifo_wr_en) begin
      out_vld <= 1'b0;
    end
  end

  always_ff @(posedge wr_clk or negedge rst) begin
    if (!rst) begin
      flush_pend <= 1'b0;
    end else if (flush_done) begin
      flush_pend <= 1'b0;
    end else if (flush_acc) begin
      flush_pend <= 1'b1;
    end
  end

  always_ff @(posedge wr_clk or negedge rst) begin
    if (!rst) begin
      words_written <= '0;
      err_overflow  <= 1'b0;
    end else begin
      if (fifo_wr_ack)
        words_written <= words_written + CNT_WIDTH'(1);
      if (fifo_overflow)
        err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mpeg2_byte_packer.sv
// Directed bench for mpeg2_byte_packer with a word scoreboard and FIFO ack model.
module tb_mpeg2_byte_packer;

  localparam int BPW = 8;
  localparam int W   = 8 * BPW;
  localparam int CW  = 4;

  logic          rst;
  logic          wr_clk;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_flush;
  logic          busy;
  logic [W-1:0]  fifo_din;
  logic          fifo_wr_en;
  logic          fifo_full;
  logic          fifo_prog_full;
  logic          fifo_wr_ack;
  logic          fifo_overflow;
  logic [CW-1:0] words_written;
  logic          err_overflow;
  logic          flush_done;

  logic          ack_q;
  logic          ack_inj;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int fd_cnt = 0;
  int busy_seen = 0;
  bit stream_chk = 0;
  int wr_cyc[$];
  logic [W-1:0] sb[$];
  logic [W-1:0] m_acc = '0;
  int m_cnt = 0;

  mpeg2_byte_packer #(
    .BYTES_PER_WORD (BPW),
    .CNT_WIDTH      (CW)
  ) dut (
    .rst            (rst),
    .wr_clk         (wr_clk),
    .byte_in        (byte_in),
    .byte_valid     (byte_valid),
    .byte_flush     (byte_flush),
    .busy           (busy),
    .fifo_din       (fifo_din),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_full      (fifo_full),
    .fifo_prog_full (fifo_prog_full),
    .fifo_wr_ack    (fifo_wr_ack),
    .fifo_overflow  (fifo_overflow),
    .words_written  (words_written),
    .err_overflow   (err_overflow),
    .flush_done     (flush_done)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  always @(posedge wr_clk) begin
    cyc   <= cyc + 1;
    ack_q <= fifo_wr_en;
  end
  assign fifo_wr_ack = ack_q | ack_inj;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: a write happens on the edge following this sample.
  always @(negedge wr_clk) begin
    if (flush_done) fd_cnt++;
    if (stream_chk && busy) busy_seen++;
    if (fifo_wr_en) begin
      wr_cnt++;
      wr_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_write observed=%0h expected=none", fifo_din);
      end else begin
        check("wr_data", fifo_din, sb.pop_front());
      end
    end
  end

  // Drive one request at posedge+1; returns at posedge+1 after acceptance.
  task automatic put(input logic [7:0] b, input logic v, input logic f);
    int n = 0;
    byte_in    = b;
    byte_valid = v;
    byte_flush = f;
    @(negedge wr_clk);
    while (busy && n < 200) begin
      @(negedge wr_clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout observed=busy expected=accept");
    end
    @(posedge wr_clk);
    #1;
    byte_valid = 1'b0;
    byte_flush = 1'b0;
    if (v) begin
      m_acc[(BPW-1-m_cnt)*8 +: 8] = b;
      m_cnt++;
      if (m_cnt == BPW) begin
        sb.push_back(m_acc);
        m_acc = '0;
        m_cnt = 0;
      end
    end
    if (f && m_cnt > 0) begin
      sb.push_back(m_acc);
      m_acc = '0;
      m_cnt = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge wr_clk);
    #1;
  endtask

  initial begin
    int w0;
    rst = 1'b0; byte_in = '0; byte_valid = 1'b0; byte_flush = 1'b0;
    fifo_full = 1'b0; fifo_prog_full = 1'b0; fifo_overflow = 1'b0; ack_inj = 1'b0;
    idle(3);
    check("rst_busy", W'(busy), W'(1));
    check("rst_wr_en", W'(fifo_wr_en), W'(0));
    check("rst_din", fifo_din, W'(0));
    check("rst_words", W'(words_written), W'(0));
    check("rst_err", W'(err_overflow), W'(0));
    check("rst_flush_done", W'(flush_done), W'(0));
    rst = 1'b1;

    // Single word and first-write latency
    for (int i = 1; i <= 8; i++) put(8'(i), 1'b1, 1'b0);
    check("lat_wr_en", W'(fifo_wr_en), W'(1));
    check("lat_din", fifo_din, 64'h0102030405060708);
    idle(3);
    check("words_1", W'(words_written), W'(1));

    // Back-to-back stream of three words
    wr_cyc.delete();
    stream_chk = 1;
    for (int i = 0; i < 24; i++) put(8'(8'h40 + i), 1'b1, 1'b0);
    idle(3);
    stream_chk = 0;
    check("stream_no_busy", W'(busy_seen), W'(0));
    check("stream_words", W'(wr_cyc.size()), W'(3));
    if (wr_cyc.size() == 3) begin
      check("stream_gap1", W'(wr_cyc[1] - wr_cyc[0]), W'(8));
      check("stream_gap2", W'(wr_cyc[2] - wr_cyc[1]), W'(8));
    end

    // Full back-pressure
    w0 = wr_cnt;
    fifo_full = 1'b1;
    for (int i = 1; i <= 8; i++) put(8'(8'h10 + i), 1'b1, 1'b0);
    for (int i = 1; i <= 7; i++) put(8'(8'h20 + i), 1'b1, 1'b0);
    check("full_busy", W'(busy), W'(1));
    idle(3);
    check("full_hold_din", fifo_din, 64'h1112131415161718);
    check("full_wr_en", W'(fifo_wr_en), W'(0));
    check("full_no_write", W'(wr_cnt - w0), W'(0));
    fifo_full = 1'b0;
    put(8'h28, 1'b1, 1'b0);
    idle(4);
    check("full_drain_words", W'(wr_cnt - w0), W'(2));

    // Flush with partial word, then empty flush
    w0 = wr_cnt;
    put(8'hAA, 1'b1, 1'b0);
    put(8'hBB, 1'b1, 1'b0);
    put(8'hCC, 1'b1, 1'b1);
    check("flush_busy", W'(busy), W'(1));
    idle(5);
    check("flush_done_once", W'(fd_cnt), W'(1));
    check("flush_busy_clear", W'(busy), W'(0));
    check("flush_words", W'(wr_cnt - w0), W'(1));
    put(8'h00, 1'b0, 1'b1);
    idle(4);
    check("flush0_done", W'(fd_cnt), W'(2));
    check("flush0_no_write", W'(wr_cnt - w0), W'(1));
    check("words_before_rst", W'(words_written), W'(7));

    // Reset mid-word with a held word in the output register
    fifo_full = 1'b1;
    for (int i = 1; i <= 8; i++) put(8'(8'h30 + i), 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) put(8'(8'h40 + i), 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_rst_wr_en", W'(fifo_wr_en), W'(0));
    check("mid_rst_din", fifo_din, W'(0));
    check("mid_rst_busy", W'(busy), W'(1));
    sb.delete();
    m_acc = '0;
    m_cnt = 0;
    idle(2);
    fifo_full = 1'b0;
    rst = 1'b1;
    w0 = wr_cnt;
    for (int i = 1; i <= 8; i++) put(8'(i), 1'b1, 1'b0);
    check("post_rst_din", fifo_din, 64'h0102030405060708);
    idle(3);
    check("post_rst_words", W'(wr_cnt - w0), W'(1));
    check("post_rst_count", W'(words_written), W'(1));

    // Overflow flag and counter wrap
    fifo_overflow = 1'b1;
    idle(1);
    fifo_overflow = 1'b0;
    check("ovf_set", W'(err_overflow), W'(1));
    idle(5);
    check("ovf_sticky", W'(err_overflow), W'(1));
    ack_inj = 1'b1;
    idle(14);
    ack_inj = 1'b0;
    check("words_all_ones", W'(words_written), W'(15));
    ack_inj = 1'b1;
    idle(1);
    ack_inj = 1'b0;
    check("words_wrap", W'(words_written), W'(0));
    rst = 1'b0;
    #1;
    check("ovf_reset", W'(err_overflow), W'(0));
    check("sb_empty", W'(sb.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
